// File: rtl/dflow_tuple_pkt_builder.sv
// dflow_tuple_pkt_builder
// Turns each accepted 5-tuple plus frame length into one zero-payload
// Ethernet/IPv4/UDP frame on a 64-bit AXI4-Stream master. The IPv4 header
// checksum is computed in a dedicated cycle between acceptance and the
// first beat, so the header is fully known before anything goes out.
module dflow_tuple_pkt_builder #(
  parameter logic [47:0] SRC_MAC            = 48'h000A35000001,
  parameter logic [47:0] DST_MAC            = 48'h000A35000002,
  parameter logic [7:0]  TTL                = 8'd64,
  parameter int          MAX_PKT_LEN        = 1514,
  parameter int          ACTION_TUPLE_WIDTH = 128,
  parameter int          PKT_TUPLE_WIDTH    = 104
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ACTION_TUPLE_WIDTH-1:0] tuple_in_transtuple_DATA,
  input  logic                          tuple_in_transtuple_VALID,
  input  logic [PKT_TUPLE_WIDTH-1:0]    tuple_in_fivetuple_DATA,
  output logic                          tuple_in_ready,
  output logic [63:0]                   m_axis_tdata,
  output logic [7:0]                    m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [31:0]                   pkt_count
);

  localparam logic [15:0] MinLen = 16'd60;
  localparam logic [15:0] MaxLen = 16'(MAX_PKT_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CSUM = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0] srcIp_q, dstIp_q;
  logic [15:0] srcPort_q, dstPort_q;
  logic [7:0]  proto_q;
  logic [15:0] len_q, lastBeat_q, beat_q;
  logic [15:0] frameId_q, ipId_q, csum_q;
  logic [31:0] pktCount_q;

  logic [15:0]  lenIn, lenClamp, ipLen, udpLen;
  logic [19:0]  csumSum;
  logic [16:0]  csumFold1;
  logic [15:0]  csumFold2;
  logic         accept, beatFire, lastFire;
  logic [383:0] hdrVec;
  logic [63:0]  hdrWord;
  logic         unused_ok;

  // Only the low 16 bits of the transtuple carry the frame length.
  assign unused_ok = ^tuple_in_transtuple_DATA[ACTION_TUPLE_WIDTH-1:16];
  assign lenIn     = tuple_in_transtuple_DATA[15:0];
  assign lenClamp  = (lenIn > MaxLen) ? MaxLen : ((lenIn < MinLen) ? MinLen : lenIn);

  // L >= 60 is guaranteed by the clamp, so neither subtraction can underflow.
  assign ipLen  = len_q - 16'd14;
  assign udpLen = len_q - 16'd34;

  // Ten header words fit in 20 bits; two end-around folds always settle the carry.
  assign csumSum = 20'h04500 + {4'h0, ipLen} + {4'h0, frameId_q} + 20'h04000
                 + {4'h0, TTL, proto_q}
                 + {4'h0, srcIp_q[31:16]} + {4'h0, srcIp_q[15:0]}
                 + {4'h0, dstIp_q[31:16]} + {4'h0, dstIp_q[15:0]};
  assign csumFold1 = {1'b0, csumSum[15:0]} + {13'h0, csumSum[19:16]};
  assign csumFold2 = csumFold1[15:0] + {15'h0, csumFold1[16]};

  // Header bytes 0..41 in wire order, padded with zeros to six full beats.
  assign hdrVec = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, ipLen, frameId_q,
                   16'h4000, TTL, proto_q, csum_q, srcIp_q, dstIp_q,
                   srcPort_q, dstPort_q, udpLen, 16'h0000, 48'h0};

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus the handshake strobes that steer the datapath.
  always_comb begin
    state_d        = state_q;
    tuple_in_ready = 1'b0;
    accept         = 1'b0;
    beatFire       = 1'b0;
    lastFire       = 1'b0;
    case (state_q)
      IDLE: begin
        tuple_in_ready = ~reset;
        if (tuple_in_transtuple_VALID && !reset) begin
          accept  = 1'b1;
          state_d = CSUM;
        end
      end
      CSUM: state_d = SEND;
      SEND: begin
        beatFire = m_axis_tready;
        if (m_axis_tready && (beat_q == lastBeat_q)) begin
          lastFire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tuple capture, checksum register, beat counter and frame counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srcIp_q    <= '0;
      dstIp_q    <= '0;
      srcPort_q  <= '0;
      dstPort_q  <= '0;
      proto_q    <= '0;
      len_q      <= '0;
      lastBeat_q <= '0;
      beat_q     <= '0;
      frameId_q  <= '0;
      ipId_q     <= '0;
      csum_q     <= '0;
      pktCount_q <= '0;
    end else begin
      if (accept) begin
        srcIp_q    <= tuple_in_fivetuple_DATA[103:72];
        dstIp_q    <= tuple_in_fivetuple_DATA[71:40];
        srcPort_q  <= tuple_in_fivetuple_DATA[39:24];
        dstPort_q  <= tuple_in_fivetuple_DATA[23:8];
        proto_q    <= tuple_in_fivetuple_DATA[7:0];
        len_q      <= lenClamp;
        lastBeat_q <= ((lenClamp + 16'd7) >> 3) - 16'd1;
        frameId_q  <= ipId_q;
        beat_q     <= '0;
      end
      if (state_q == CSUM) csum_q <= ~csumFold2;
      if (beatFire) begin
        if (lastFire) begin
          beat_q     <= '0;
          ipId_q     <= ipId_q + 16'd1;
          pktCount_q <= pktCount_q + 32'd1;
        end else begin
          beat_q <= beat_q + 16'd1;
        end
      end
    end
  end

  // Beat formatting: header bytes for the first six beats, zeros afterwards,
  // with wire byte n placed in lane n%8.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tkeep  = 8'h00;
    m_axis_tdata  = 64'h0;
    hdrWord       = 64'h0;
    if (state_q == SEND) begin
      m_axis_tvalid = 1'b1;
      case (beat_q)
        16'd0:   hdrWord = hdrVec[383:320];
        16'd1:   hdrWord = hdrVec[319:256];
        16'd2:   hdrWord = hdrVec[255:192];
        16'd3:   hdrWord = hdrVec[191:128];
        16'd4:   hdrWord = hdrVec[127:64];
        16'd5:   hdrWord = hdrVec[63:0];
        default: hdrWord = 64'h0;
      endcase
      for (int k = 0; k < 8; k++) begin
        m_axis_tdata[8*k +: 8] = hdrWord[63-8*k -: 8];
      end
      if (beat_q == lastBeat_q) begin
        m_axis_tlast = 1'b1;
        m_axis_tkeep = (len_q[2:0] == 3'd0) ? 8'hFF : ((8'h01 << len_q[2:0]) - 8'h01);
      end else begin
        m_axis_tkeep = 8'hFF;
      end
    end
  end

  assign pkt_count = pktCount_q;

endmodule

// File: tb/tb_dflow_tuple_pkt_builder.sv
// tb_dflow_tuple_pkt_builder
// Directed vector table for the frame builder plus hand-written sequences
// for back-to-back tuples, random backpressure and reset in mid-frame.
module tb_dflow_tuple_pkt_builder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] transData = '0;
  logic         transValid = 1'b0;
  logic [103:0] fiveData = '0;
  logic         ready;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic         tvalid, tlast;
  logic         tready = 1'b1;
  logic [31:0]  pktCount;

  int compareCount = 0;
  int mismatchCount = 0;
  bit randomTready = 1'b0;

  typedef struct {
    logic [15:0] len;
    logic [31:0] srcIp;
    logic [31:0] dstIp;
    logic [15:0] srcPort;
    logic [15:0] dstPort;
    logic [7:0]  proto;
    int          expBeats;
    logic [7:0]  expLastKeep;
    logic [15:0] expIpLen;
    logic [15:0] expUdpLen;
    logic [15:0] expCsum;
    logic [15:0] expIpId;
  } vec_t;

  typedef struct {
    int         beats;
    logic [7:0] lastKeep;
    bit         midKeepBad;
  } frame_info_t;

  vec_t vecs[6];

  frame_info_t doneInfo[$];
  logic [7:0]  doneBytes[$];
  logic [7:0]  curBytes[$];
  int          curBeats = 0;
  bit          curMidBad = 1'b0;
  bit          stallPending = 1'b0;
  logic [63:0] prevData;
  logic [7:0]  prevKeep;
  logic        prevLast;

  frame_info_t gotInfo;
  logic [7:0]  gotBytes[$];

  logic [7:0]  expBytes[1520];
  logic [15:0] expL;
  logic [15:0] expCsum;
  logic [47:0] macDst = 48'h000A35000002;
  logic [47:0] macSrc = 48'h000A35000001;

  always #5 clk = ~clk;

  dflow_tuple_pkt_builder dut (
    .clk                       (clk),
    .reset                     (reset),
    .tuple_in_transtuple_DATA  (transData),
    .tuple_in_transtuple_VALID (transValid),
    .tuple_in_fivetuple_DATA   (fiveData),
    .tuple_in_ready            (ready),
    .m_axis_tdata              (tdata),
    .m_axis_tkeep              (tkeep),
    .m_axis_tvalid             (tvalid),
    .m_axis_tlast              (tlast),
    .m_axis_tready             (tready),
    .pkt_count                 (pktCount)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // tready driver: steady 1, or a fair coin when backpressure is enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tready = randomTready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Beat monitor: collects handshaken beats into frames and polices stall stability
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        curBytes.delete();
        curBeats = 0;
        curMidBad = 1'b0;
        stallPending = 1'b0;
      end else begin
        if (stallPending) begin
          checkOutput("stall_data", tdata, prevData);
          checkOutput("stall_ctl", {tvalid, tlast, tkeep}, {1'b1, prevLast, prevKeep});
        end else if (curBeats > 0) begin
          checkOutput("valid_mid_frame", tvalid, 1'b1);
        end
        if (tvalid && tready) begin
          for (int k = 0; k < 8; k++) curBytes.push_back(tdata[8*k +: 8]);
          curBeats++;
          if (!tlast && tkeep != 8'hFF) curMidBad = 1'b1;
          if (tlast) begin
            doneInfo.push_back('{curBeats, tkeep, curMidBad});
            foreach (curBytes[i]) doneBytes.push_back(curBytes[i]);
            curBytes.delete();
            curBeats = 0;
            curMidBad = 1'b0;
          end
        end
        stallPending = tvalid && !tready;
        prevData = tdata;
        prevKeep = tkeep;
        prevLast = tlast;
      end
    end
  end

  // Safety net in case some wait is never satisfied
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] clampLen(input logic [15:0] len);
    if (len > 16'd1514) return 16'd1514;
    if (len < 16'd60) return 16'd60;
    return len;
  endfunction

  // Reference frame from the byte map, with a word-by-word end-around-carry checksum
  task automatic buildExpected(input vec_t v, input logic [15:0] ipId);
    logic [15:0] w[10];
    int acc;
    expL = clampLen(v.len);
    w[0] = 16'h4500;          w[1] = expL - 16'd14;     w[2] = ipId;
    w[3] = 16'h4000;          w[4] = {8'd64, v.proto};  w[5] = 16'h0000;
    w[6] = v.srcIp[31:16];    w[7] = v.srcIp[15:0];
    w[8] = v.dstIp[31:16];    w[9] = v.dstIp[15:0];
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      acc = acc + int'(w[i]);
      if (acc > 32'h0000FFFF) acc = acc - 32'h0000FFFF;
    end
    expCsum = ~16'(acc);
    for (int n = 0; n < 1520; n++) expBytes[n] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      expBytes[i]     = macDst[47-8*i -: 8];
      expBytes[6 + i] = macSrc[47-8*i -: 8];
    end
    expBytes[12] = 8'h08; expBytes[13] = 8'h00;
    expBytes[14] = 8'h45; expBytes[15] = 8'h00;
    expBytes[16] = w[1][15:8];      expBytes[17] = w[1][7:0];
    expBytes[18] = ipId[15:8];      expBytes[19] = ipId[7:0];
    expBytes[20] = 8'h40;           expBytes[21] = 8'h00;
    expBytes[22] = 8'd64;           expBytes[23] = v.proto;
    expBytes[24] = expCsum[15:8];   expBytes[25] = expCsum[7:0];
    for (int i = 0; i < 4; i++) begin
      expBytes[26 + i] = v.srcIp[31-8*i -: 8];
      expBytes[30 + i] = v.dstIp[31-8*i -: 8];
    end
    expBytes[34] = v.srcPort[15:8]; expBytes[35] = v.srcPort[7:0];
    expBytes[36] = v.dstPort[15:8]; expBytes[37] = v.dstPort[7:0];
    expBytes[38] = 8'((expL - 16'd34) >> 8);
    expBytes[39] = 8'(expL - 16'd34);
  endtask

  task automatic driveTuple(input vec_t v);
    transData = {$urandom, $urandom, $urandom, 16'hA5A5, v.len};
    fiveData  = {v.srcIp, v.dstIp, v.srcPort, v.dstPort, v.proto};
  endtask

  // Offer one tuple, wait for acceptance, then check the CSUM gap and first-beat latency
  task automatic applyStimulus(input vec_t v);
    bit accepted = 1'b0;
    @(posedge clk);
    #1;
    driveTuple(v);
    transValid = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (ready) begin
        accepted = 1'b1;
        break;
      end
    end
    checkOutput("tuple_accepted", accepted, 1'b1);
    @(posedge clk);
    #1;
    transValid = 1'b0;
    if (accepted) begin
      @(negedge clk);
      checkOutput("csum_cycle", {tvalid, ready}, 2'b00);
      @(negedge clk);
      checkOutput("first_valid", tvalid, 1'b1);
    end
  endtask

  task automatic popFrame(input int budget, output bit ok);
    int waited = 0;
    while (doneInfo.size() == 0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    ok = (doneInfo.size() > 0);
    checkOutput("frame_arrived", ok, 1'b1);
    gotBytes.delete();
    if (ok) begin
      gotInfo = doneInfo.pop_front();
      for (int i = 0; i < gotInfo.beats * 8; i++) gotBytes.push_back(doneBytes.pop_front());
    end
    while (gotBytes.size() < 1520) gotBytes.push_back(8'hxx);
  endtask

  task automatic checkFrame(input int expBeats, input logic [7:0] expKeep);
    int bad = 0;
    int firstBad = -1;
    checkOutput("beat_count", gotInfo.beats, expBeats);
    checkOutput("last_tkeep", gotInfo.lastKeep, expKeep);
    checkOutput("mid_tkeep", gotInfo.midKeepBad, 1'b0);
    for (int n = 0; n < int'(expL); n++) begin
      if (gotBytes[n] !== expBytes[n]) begin
        if (firstBad < 0) firstBad = n;
        bad++;
      end
    end
    if (bad != 0) $display("[TB] first differing byte index %0d", firstBad);
    checkOutput("frame_bytes", bad, 0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    transValid = 1'b0;
    #1;
    checkOutput("rst_tvalid", tvalid, 1'b0);
    checkOutput("rst_tlast", tlast, 1'b0);
    checkOutput("rst_tkeep", tkeep, 8'h00);
    checkOutput("rst_tdata", tdata, 64'h0);
    checkOutput("rst_ready", ready, 1'b0);
    checkOutput("rst_pkt_count", pktCount, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", ready, 1'b1);
  endtask

  initial begin
    bit ok;
    vec_t rv;
    int accepts;
    int nLast;
    int acceptCyc[3];
    int lastCyc[3];
    int seen;
    logic [7:0] rKeep;

    vecs[0] = '{16'd64,   32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, 8'h11, 8,   8'hFF, 16'h0032, 16'h001E, 16'h26B9, 16'd0};
    vecs[1] = '{16'd61,   32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, 8'h11, 8,   8'h1F, 16'h002F, 16'h001B, 16'h26BB, 16'd1};
    vecs[2] = '{16'd30,   32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, 8'h11, 8,   8'h0F, 16'h002E, 16'h001A, 16'h26BB, 16'd2};
    vecs[3] = '{16'd2000, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, 8'h11, 190, 8'h03, 16'h05DC, 16'h05C8, 16'h210C, 16'd3};
    vecs[4] = '{16'd100,  32'hC0A80164, 32'hAC10FE01, 16'h0050, 16'h1F90, 8'h06, 13,  8'h0F, 16'h0056, 16'h0042, 16'hCE7F, 16'd4};
    vecs[5] = '{16'd1515, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, 8'h11, 190, 8'h03, 16'h05DC, 16'h05C8, 16'h210A, 16'd5};

    $display("[TB] reset state");
    doReset();

    $display("[TB] directed vector table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      buildExpected(vecs[i], vecs[i].expIpId);
      popFrame(2000, ok);
      if (ok) begin
        checkFrame(vecs[i].expBeats, vecs[i].expLastKeep);
        checkOutput("ip_total_len", {gotBytes[16], gotBytes[17]}, vecs[i].expIpLen);
        checkOutput("ip_id", {gotBytes[18], gotBytes[19]}, vecs[i].expIpId);
        checkOutput("ip_checksum", {gotBytes[24], gotBytes[25]}, vecs[i].expCsum);
        checkOutput("udp_len", {gotBytes[38], gotBytes[39]}, vecs[i].expUdpLen);
      end
      @(posedge clk);
      #1;
      checkOutput("pkt_count", pktCount, 32'(i + 1));
      checkOutput("ready_after_frame", ready, 1'b1);
    end

    $display("[TB] back-to-back tuples");
    doReset();
    driveTuple(vecs[0]);
    @(posedge clk);
    #1;
    transValid = 1'b1;
    accepts = 0;
    nLast = 0;
    for (int i = 0; i < 3; i++) begin
      acceptCyc[i] = -100;
      lastCyc[i] = -100;
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tvalid && tready && tlast && nLast < 3) begin
        lastCyc[nLast] = c;
        nLast++;
      end
      if (ready) begin
        acceptCyc[accepts] = c;
        accepts++;
      end
      if (accepts == 3) break;
    end
    @(posedge clk);
    #1;
    transValid = 1'b0;
    checkOutput("b2b_accepts", accepts, 3);
    checkOutput("b2b_gap0", 64'(acceptCyc[1] - lastCyc[0]), 64'd1);
    checkOutput("b2b_gap1", 64'(acceptCyc[2] - lastCyc[1]), 64'd1);
    checkOutput("b2b_spacing", 64'(acceptCyc[1] - acceptCyc[0]), 64'd10);
    @(negedge clk);
    checkOutput("b2b_ready_low", ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      buildExpected(vecs[0], 16'(k));
      popFrame(400, ok);
      if (ok) begin
        checkFrame(8, 8'hFF);
        checkOutput("b2b_ip_id", {gotBytes[18], gotBytes[19]}, 64'(k));
      end
    end
    @(posedge clk);
    #1;
    checkOutput("b2b_pkt_count", pktCount, 32'd3);

    $display("[TB] random backpressure, 100 frames");
    doReset();
    randomTready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      rv = vecs[0];
      rv.len = 16'($urandom_range(16, 1600));
      rv.srcIp = $urandom;
      rv.dstIp = $urandom;
      rv.srcPort = 16'($urandom);
      rv.dstPort = 16'($urandom);
      rv.proto = 8'($urandom_range(0, 255));
      applyStimulus(rv);
      buildExpected(rv, 16'(f));
      popFrame(4000, ok);
      rKeep = (expL % 16'd8 == 16'd0) ? 8'hFF : 8'((16'd1 << (expL % 16'd8)) - 16'd1);
      if (ok) checkFrame((int'(expL) + 7) / 8, rKeep);
    end
    @(posedge clk);
    #1;
    randomTready = 1'b0;
    checkOutput("bp_pkt_count", pktCount, 32'd100);

    $display("[TB] reset in mid-frame");
    doReset();
    applyStimulus(vecs[0]);
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (tvalid && tready) seen++;
      if (seen == 3) break;
      @(negedge clk);
    end
    checkOutput("mid_beats_seen", seen, 3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_tvalid", tvalid, 1'b0);
    checkOutput("mid_rst_tlast", tlast, 1'b0);
    checkOutput("mid_rst_tdata", tdata, 64'h0);
    checkOutput("mid_rst_tkeep", tkeep, 8'h00);
    checkOutput("mid_rst_pkt_count", pktCount, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("no_partial_frame", doneInfo.size(), 0);
    applyStimulus(vecs[0]);
    buildExpected(vecs[0], 16'd0);
    popFrame(400, ok);
    if (ok) begin
      checkFrame(8, 8'hFF);
      checkOutput("post_rst_ip_id", {gotBytes[18], gotBytes[19]}, 16'h0000);
    end
    @(posedge clk);
    #1;
    checkOutput("post_rst_pkt_count", pktCount, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
